// File: rtl/counter_arbiter_if.sv
// Bundle of the requester-side and counter-side signals around counter_arbiter.
// The slave view is the arbiter itself; the master view is whatever surrounds it
// (the two requesters plus the shared up/down counter).
interface counter_arbiter_if #(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 4
);

  // requester 0 command
  logic              REQ0;
  logic [1:0]        CMD0;
  logic [WIDTH-1:0]  VAL0;
  logic [STEP_W-1:0] STEPS0;

  // requester 1 command
  logic              REQ1;
  logic [1:0]        CMD1;
  logic [WIDTH-1:0]  VAL1;
  logic [STEP_W-1:0] STEPS1;

  // counter status fed back to the arbiter
  logic [WIDTH-1:0]  Counter;
  logic              High;
  logic              Low;

  // grants and status back to the requesters
  logic              GNT0;
  logic              GNT1;
  logic              BUSY;
  logic              OWNER;
  logic              DONE;
  logic              SAT;

  // strobes to the counter
  logic [WIDTH-1:0]  IN;
  logic              Load;
  logic              Up;
  logic              Down;

  modport slave (
    input  REQ0, CMD0, VAL0, STEPS0,
    input  REQ1, CMD1, VAL1, STEPS1,
    input  Counter, High, Low,
    output GNT0, GNT1, BUSY, OWNER, DONE, SAT,
    output IN, Load, Up, Down
  );

  modport master (
    output REQ0, CMD0, VAL0, STEPS0,
    output REQ1, CMD1, VAL1, STEPS1,
    output Counter, High, Low,
    input  GNT0, GNT1, BUSY, OWNER, DONE, SAT,
    input  IN, Load, Up, Down
  );

endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lets two requesters share one 5-bit up/down counter.
// A granted command is latched, then replayed onto the counter's Load/Up/Down
// strobes one step per cycle; the command ends early if the counter reports it
// has hit the top (Up) or bottom (Down), which is flagged on SAT.
module counter_arbiter #(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 4
) (
  input logic              clk,
  input logic              rst,
  counter_arbiter_if.slave bus
);

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_NOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [WIDTH-1:0]  val_q, val_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              sat_q, sat_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;

  logic              req_any;
  logic              pick;
  logic [1:0]        pick_cmd;
  logic [WIDTH-1:0]  pick_val;
  logic [STEP_W-1:0] pick_steps;
  logic              rem_nz;
  logic              hit_limit;

  // Choose the winner: a lone requester always wins, a tie goes to whoever was not served last.
  always_comb begin
    req_any    = bus.REQ0 | bus.REQ1;
    pick       = (bus.REQ0 & bus.REQ1) ? ~last_q : bus.REQ1;
    pick_cmd   = pick ? bus.CMD1   : bus.CMD0;
    pick_val   = pick ? bus.VAL1   : bus.VAL0;
    pick_steps = pick ? bus.STEPS1 : bus.STEPS0;
  end

  // Remaining-step and counter-limit conditions used by both the FSM and the strobes.
  always_comb begin
    rem_nz    = (rem_q != '0);
    hit_limit = rem_nz && (((cmd_q == CMD_UP) && bus.High) ||
                           ((cmd_q == CMD_DOWN) && bus.Low));
  end

  // Next-state logic: capture at grant, count steps down in RUN, single DONE cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    val_d   = val_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    last_d  = last_q;
    sat_d   = sat_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          cmd_d   = pick_cmd;
          val_d   = pick_val;
          rem_d   = pick_steps;
          owner_d = pick;
          last_d  = pick;
          sat_d   = 1'b0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((cmd_q == CMD_LOAD) || (cmd_q == CMD_NOP)) begin
          state_d = ST_DONE;
        end else if (!rem_nz) begin
          state_d = ST_DONE;
        end else if (hit_limit) begin
          sat_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - STEP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset makes requester 0 the first winner of a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      val_q   <= '0;
      rem_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      sat_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      val_q   <= val_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sat_q   <= sat_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  // Counter strobes and status, decoded straight from state so a reset stops them at once.
  always_comb begin
    bus.Load  = (state_q == ST_RUN) && (cmd_q == CMD_LOAD);
    bus.Up    = (state_q == ST_RUN) && (cmd_q == CMD_UP) && rem_nz && !bus.High;
    bus.Down  = (state_q == ST_RUN) && (cmd_q == CMD_DOWN) && rem_nz && !bus.Low;
    bus.IN    = (state_q == ST_RUN) ? val_q : '0;
    bus.BUSY  = (state_q != ST_IDLE);
    bus.DONE  = (state_q == ST_DONE);
    bus.OWNER = owner_q;
    bus.SAT   = sat_q;
    bus.GNT0  = gnt0_q;
    bus.GNT1  = gnt1_q;
  end

  // The counter's flags must agree with its value, and only one strobe may fire per cycle.
  a_high_consistent: assert property (@(posedge clk) disable iff (rst)
    bus.High |-> (bus.Counter == '1));
  a_low_consistent: assert property (@(posedge clk) disable iff (rst)
    bus.Low |-> (bus.Counter == '0));
  a_one_strobe: assert property (@(posedge clk) disable iff (rst)
    $onehot0({bus.Load, bus.Up, bus.Down}));

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a plain 5-bit up/down counter sits on the strobes,
// and each served command is compared with an arithmetic model of what the
// command should do to the counter (strobe counts, final value, saturation).
module tb_counter_arbiter;

  localparam int WIDTH  = 5;
  localparam int STEP_W = 4;
  localparam int MAXV   = (1 << WIDTH) - 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  localparam int LOAD = 0;
  localparam int UP   = 1;
  localparam int DOWN = 2;
  localparam int NOP  = 3;

  logic clk = 1'b0;
  logic rst;

  counter_arbiter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus();

  counter_arbiter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checkCount = 0;
  int failCount  = 0;
  int expCount   = 0;
  int lastModel  = 1;
  int reqCmd[2];
  int reqVal[2];
  int reqSteps[2];

  logic [WIDTH-1:0] cntValue = '0;

  // Free-running clock.
  always #5 clk = ~clk;

  // The shared counter: load wins, otherwise step while not pinned at a limit.
  always @(posedge clk) begin
    if (bus.Load)
      cntValue <= bus.IN;
    else if (bus.Up && (cntValue != CNT_MAX))
      cntValue <= cntValue + 1'b1;
    else if (bus.Down && (cntValue != '0))
      cntValue <= cntValue - 1'b1;
  end

  assign bus.Counter = cntValue;
  assign bus.High    = (cntValue == CNT_MAX);
  assign bus.Low     = (cntValue == '0);

  // Safety net so a stuck design can never hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic driveReq(input int id, input int req, input int cmd, input int val, input int steps);
    if (id == 0) begin
      bus.REQ0   = (req != 0);
      bus.CMD0   = 2'(cmd);
      bus.VAL0   = WIDTH'(val);
      bus.STEPS0 = STEP_W'(steps);
    end else begin
      bus.REQ1   = (req != 0);
      bus.CMD1   = 2'(cmd);
      bus.VAL1   = WIDTH'(val);
      bus.STEPS1 = STEP_W'(steps);
    end
  endtask

  // What one command does to a counter starting at 'start'.
  function automatic void refCommand(input int start, input int cmd, input int val, input int steps,
                                     output int loads, output int ups, output int downs,
                                     output int finalValue, output int sat);
    int room;
    loads = 0; ups = 0; downs = 0; sat = 0; finalValue = start;
    case (cmd)
      LOAD: begin
        loads = 1;
        finalValue = val;
      end
      UP: begin
        room = MAXV - start;
        ups = (steps < room) ? steps : room;
        sat = (steps > room) ? 1 : 0;
        finalValue = start + ups;
      end
      DOWN: begin
        room = start;
        downs = (steps < room) ? steps : room;
        sat = (steps > room) ? 1 : 0;
        finalValue = start - downs;
      end
      default: ;
    endcase
  endfunction

  // Post requests (mask bit0 = req 0, bit1 = req 1) and follow each one through to DONE.
  task automatic applyStimulus(input int mask, input int c0, input int v0, input int s0,
                               input int c1, input int v1, input int s1);
    int pending, expWin, waited, gntSeen, id;
    int eLoads, eUps, eDowns, eFinal, eSat;
    int nLoads, nUps, nDowns, gntCycles, busyBad, ownerBad, inBad, doneSeen;
    pending = mask;
    reqCmd[0] = c0; reqVal[0] = v0; reqSteps[0] = s0;
    reqCmd[1] = c1; reqVal[1] = v1; reqSteps[1] = s1;
    driveReq(0, mask & 1, c0, v0, s0);
    driveReq(1, mask & 2, c1, v1, s1);
    while (pending != 0) begin
      expWin = (pending == 3) ? (1 - lastModel) : ((pending == 2) ? 1 : 0);
      waited = 0;
      gntSeen = 0;
      while (gntSeen == 0 && waited < 4) begin
        @(negedge clk);
        waited++;
        if (bus.GNT0 && bus.GNT1) checkOutput("dual_grant", 1, 0);
        gntSeen = (bus.GNT0 || bus.GNT1) ? 1 : 0;
      end
      checkOutput("grant_seen", gntSeen, 1);
      if (gntSeen == 0) begin
        driveReq(0, 0, NOP, 0, 0);
        driveReq(1, 0, NOP, 0, 0);
        return;
      end
      checkOutput("grant_id", bus.GNT1 ? 1 : 0, expWin);
      checkOutput("grant_latency", waited, 1);
      checkOutput("sat_clear_at_grant", int'(bus.SAT), 0);
      id = expWin;
      // Command inputs are only meaningful at the grant edge; scramble them afterwards.
      driveReq(id, 0, $urandom_range(0, 3), $urandom_range(0, MAXV), $urandom_range(0, 15));
      refCommand(expCount, reqCmd[id], reqVal[id], reqSteps[id], eLoads, eUps, eDowns, eFinal, eSat);
      nLoads = 0; nUps = 0; nDowns = 0; gntCycles = 0;
      busyBad = 0; ownerBad = 0; inBad = 0; doneSeen = 0;
      for (int c = 0; c < 24 && doneSeen == 0; c++) begin
        if (c > 0) @(negedge clk);
        if (bus.GNT0 && bus.GNT1) checkOutput("dual_grant", 1, 0);
        if (bus.DONE) begin
          doneSeen = 1;
          if (!bus.BUSY) busyBad++;
        end else begin
          if (bus.Load) nLoads++;
          if (bus.Up) nUps++;
          if (bus.Down) nDowns++;
          if (bus.GNT0 || bus.GNT1) gntCycles++;
          if (!bus.BUSY) busyBad++;
          if (int'(bus.OWNER) != id) ownerBad++;
          if (bus.Load && (int'(bus.IN) != reqVal[id])) inBad++;
        end
      end
      checkOutput("done_seen", doneSeen, 1);
      checkOutput("load_strobes", nLoads, eLoads);
      checkOutput("up_strobes", nUps, eUps);
      checkOutput("down_strobes", nDowns, eDowns);
      checkOutput("grant_width", gntCycles, 1);
      checkOutput("busy_window", busyBad, 0);
      checkOutput("owner", ownerBad, 0);
      checkOutput("in_value", inBad, 0);
      checkOutput("sat_at_done", int'(bus.SAT), eSat);
      checkOutput("counter_at_done", int'(bus.Counter), eFinal);
      @(negedge clk);
      checkOutput("done_pulse_width", int'(bus.DONE), 0);
      checkOutput("idle_after_done", int'(bus.BUSY), 0);
      checkOutput("sat_held", int'(bus.SAT), eSat);
      expCount = eFinal;
      lastModel = id;
      pending = pending & ~(1 << id);
    end
  endtask

  initial begin
    int downsSeen;
    int gntWait;
    rst = 1'b1;
    driveReq(0, 1, LOAD, 7, 0);
    driveReq(1, 0, NOP, 0, 0);
    $display("[TB] reset with requester 0 asking");
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_outputs",
                  int'({bus.GNT0, bus.GNT1, bus.Load, bus.Up, bus.Down, bus.DONE,
                        bus.SAT, bus.BUSY, bus.OWNER, bus.IN}), 0);
    end
    rst = 1'b0;
    driveReq(0, 0, NOP, 0, 0);
    expCount = 0;
    lastModel = 1;

    $display("[TB] directed sequences");
    applyStimulus(3, LOAD, 15, 0, UP, 0, 3);
    applyStimulus(3, UP, 0, 2, DOWN, 0, 1);
    applyStimulus(1, LOAD, 29, 0, NOP, 0, 0);
    applyStimulus(2, NOP, 0, 0, UP, 0, 5);
    applyStimulus(1, LOAD, 2, 0, NOP, 0, 0);
    applyStimulus(2, NOP, 0, 0, DOWN, 0, 4);
    applyStimulus(1, UP, 0, 0, NOP, 0, 0);
    applyStimulus(2, NOP, 9, 0, NOP, 3, 7);
    applyStimulus(1, LOAD, 20, 0, NOP, 0, 0);

    $display("[TB] reset during a long DOWN");
    driveReq(0, 1, DOWN, 0, 8);
    gntWait = 0;
    do begin
      @(negedge clk);
      gntWait++;
    end while (!bus.GNT0 && gntWait < 4);
    checkOutput("abort_grant", int'(bus.GNT0), 1);
    driveReq(0, 0, NOP, 0, 0);
    downsSeen = bus.Down ? 1 : 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.Down) downsSeen++;
    end
    checkOutput("abort_downs_before_reset", downsSeen, 3);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_quiet",
                  int'({bus.Down, bus.Up, bus.Load, bus.BUSY, bus.DONE, bus.GNT0, bus.GNT1}), 0);
    end
    rst = 1'b0;
    checkOutput("abort_counter", int'(bus.Counter), 17);
    expCount = 17;
    lastModel = 1;
    applyStimulus(2, NOP, 0, 0, UP, 0, 2);

    $display("[TB] randomized commands");
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(1, 3),
                    $urandom_range(0, 3), $urandom_range(0, MAXV), $urandom_range(0, 15),
                    $urandom_range(0, 3), $urandom_range(0, MAXV), $urandom_range(0, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
